// File: rtl/aes_decrypt_iter.sv
// Iterative AES-128 decryption core: forward-expands the cipher key to round
// key 10, then runs ten inverse rounds one per clock while rolling the round
// key backwards. Byte 0 of the state is bit 127; the state is column-major.
module aes_decrypt_iter (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [127:0] key,
   input  logic [127:0] ciphertext,
   output logic         busy,
   output logic         done,
   output logic [127:0] plaintext
);

   typedef enum logic [1:0] {IDLE, KEYEXP, INITARK, ROUND} state_t;

   state_t       fsm;
   logic [127:0] rk_reg;
   logic [127:0] state_reg;
   logic [3:0]   rnd;

   logic [127:0] fwd_rk;
   logic [127:0] inv_rk;
   logic [127:0] last_out;
   logic [127:0] round_out;

   // GF(2^8) multiply modulo x^8+x^4+x^3+x+1
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, aa, bb;
      p  = 8'h00;
      aa = a;
      bb = b;
      for (int unsigned i = 0; i < 8; i++) begin
         if (bb[0]) p = p ^ aa;
         aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
         bb = {1'b0, bb[7:1]};
      end
      return p;
   endfunction

   // Multiplicative inverse as x^254 (maps 0 to 0)
   function automatic logic [7:0] gf_inv(input logic [7:0] x);
      logic [7:0] sq, r;
      sq = x;
      r  = 8'h01;
      for (int unsigned i = 0; i < 7; i++) begin
         sq = gmul(sq, sq);
         r  = gmul(r, sq);
      end
      return r;
   endfunction

   function automatic logic [7:0] sbox(input logic [7:0] x);
      logic [7:0] b;
      b = gf_inv(x);
      return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^
             {b[3:0], b[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [7:0] inv_sbox(input logic [7:0] y);
      return gf_inv({y[6:0], y[7]} ^ {y[4:0], y[7:5]} ^ {y[1:0], y[7:2]} ^ 8'h05);
   endfunction

   function automatic logic [31:0] sub_rot_word(input logic [31:0] w);
      logic [31:0] r;
      r = {w[23:0], w[31:24]};
      return {sbox(r[31:24]), sbox(r[23:16]), sbox(r[15:8]), sbox(r[7:0])};
   endfunction

   function automatic logic [7:0] rcon(input logic [3:0] r);
      case (r)
         4'd1:    return 8'h01;
         4'd2:    return 8'h02;
         4'd3:    return 8'h04;
         4'd4:    return 8'h08;
         4'd5:    return 8'h10;
         4'd6:    return 8'h20;
         4'd7:    return 8'h40;
         4'd8:    return 8'h80;
         4'd9:    return 8'h1b;
         4'd10:   return 8'h36;
         default: return 8'h00;
      endcase
   endfunction

   function automatic logic [127:0] fwd_expand(input logic [127:0] rk, input logic [7:0] rc);
      logic [31:0] n0, n1, n2, n3;
      n0 = rk[127:96] ^ sub_rot_word(rk[31:0]) ^ {rc, 24'h0};
      n1 = rk[95:64] ^ n0;
      n2 = rk[63:32] ^ n1;
      n3 = rk[31:0] ^ n2;
      return {n0, n1, n2, n3};
   endfunction

   function automatic logic [127:0] inv_expand(input logic [127:0] rk, input logic [7:0] rc);
      logic [31:0] n0, n1, n2, n3;
      n3 = rk[31:0] ^ rk[63:32];
      n2 = rk[63:32] ^ rk[95:64];
      n1 = rk[95:64] ^ rk[127:96];
      n0 = rk[127:96] ^ sub_rot_word(n3) ^ {rc, 24'h0};
      return {n0, n1, n2, n3};
   endfunction

   function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
      return {s[127:120], s[23:16],  s[47:40],  s[71:64],
              s[95:88],   s[119:112], s[15:8],  s[39:32],
              s[63:56],   s[87:80],  s[111:104], s[7:0],
              s[31:24],   s[55:48],  s[79:72],  s[103:96]};
   endfunction

   function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
      logic [127:0] in, out;
      in  = s;
      out = '0;
      for (int unsigned i = 0; i < 16; i++) begin
         out = {out[119:0], inv_sbox(in[127:120])};
         in  = {in[119:0], 8'h00};
      end
      return out;
   endfunction

   function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
      logic [7:0] a0, a1, a2, a3;
      {a0, a1, a2, a3} = c;
      return {gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
              gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
              gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
              gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
   endfunction

   function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
      logic [127:0] in, out;
      in  = s;
      out = '0;
      for (int unsigned i = 0; i < 4; i++) begin
         out = {out[95:0], inv_mix_col(in[127:96])};
         in  = {in[95:0], 32'h0};
      end
      return out;
   endfunction

   // Key schedule steps and inverse-round datapath for the current rnd/state
   always_comb begin
      fwd_rk    = fwd_expand(rk_reg, rcon(rnd));
      inv_rk    = inv_expand(rk_reg, rcon(rnd));
      last_out  = inv_sub_bytes(inv_shift_rows(state_reg)) ^ rk_reg;
      round_out = inv_mix_columns(last_out);
   end

   // Control FSM with registered outputs; rnd stays at 10 on leaving KEYEXP
   // so INITARK picks up rcon(10) through the shared inverse-expand path
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fsm       <= IDLE;
         busy      <= 1'b0;
         done      <= 1'b0;
         plaintext <= '0;
         rnd       <= '0;
         rk_reg    <= '0;
         state_reg <= '0;
      end else begin
         done <= 1'b0;
         case (fsm)
            IDLE: begin
               if (start) begin
                  rk_reg    <= key;
                  state_reg <= ciphertext;
                  rnd       <= 4'd1;
                  busy      <= 1'b1;
                  fsm       <= KEYEXP;
               end
            end
            KEYEXP: begin
               rk_reg <= fwd_rk;
               if (rnd == 4'd10) fsm <= INITARK;
               else              rnd <= rnd + 4'd1;
            end
            INITARK: begin
               state_reg <= state_reg ^ rk_reg;
               rk_reg    <= inv_rk;
               rnd       <= 4'd9;
               fsm       <= ROUND;
            end
            ROUND: begin
               if (rnd == 4'd0) begin
                  plaintext <= last_out;
                  done      <= 1'b1;
                  busy      <= 1'b0;
                  fsm       <= IDLE;
               end else begin
                  state_reg <= round_out;
                  rk_reg    <= inv_rk;
                  rnd       <= rnd - 4'd1;
               end
            end
            default: fsm <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_aes_decrypt_iter.sv
// Self-checking bench for aes_decrypt_iter: known-answer vectors through a
// plaintext scoreboard, plus timing, back-to-back, ignored-start and reset cases.
module tb_aes_decrypt_iter;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start;
   logic [127:0] key;
   logic [127:0] ciphertext;
   logic         busy;
   logic         done;
   logic [127:0] plaintext;

   typedef struct {
      logic [127:0] key;
      logic [127:0] ct;
      logic [127:0] pt;
   } vec_t;

   vec_t         vecs [3];
   logic [127:0] sb_q [$];
   logic [127:0] last_pt;
   int           checks   = 0;
   int           failures = 0;

   aes_decrypt_iter dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .key        (key),
      .ciphertext (ciphertext),
      .busy       (busy),
      .done       (done),
      .plaintext  (plaintext)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Scoreboard: every done pops one expected plaintext
   always @(negedge clk) begin
      if (rst_n === 1'b1 && done === 1'b1) begin
         if (sb_q.size() == 0) chk("spurious_done", {127'b0, done}, '0);
         else                  chk("plaintext", plaintext, sb_q.pop_front());
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog timeout checks=%0d", checks);
      $fatal(1);
   end

   task automatic run_op(input vec_t v, input bit probe);
      int lat, busy_n;
      @(negedge clk);
      start = 1'b1; key = v.key; ciphertext = v.ct;
      sb_q.push_back(v.pt);
      @(negedge clk);
      start = 1'b0; key = {4{$urandom}}; ciphertext = {4{$urandom}};
      lat = -1; busy_n = 0;
      for (int i = 0; i < 40; i++) begin
         if (busy) busy_n++;
         if (probe && i == 10) chk("rk10", dut.rk_reg, 128'h13111d7fe3944a17f307a78b4d2b30c5);
         if (probe && i == 20) chk("rk_final", dut.rk_reg, v.key);
         if (done) begin lat = i; break; end
         @(negedge clk);
      end
      chk("latency", lat, 21);
      chk("busy_cycles", busy_n, 21);
      last_pt = v.pt;
   endtask

   initial begin
      int lat, lat2, ndone;
      vecs[0] = '{128'h000102030405060708090a0b0c0d0e0f,
                  128'h69c4e0d86a7b0430d8cdb78070b4c55a,
                  128'h00112233445566778899aabbccddeeff};
      vecs[1] = '{128'h5468617473206d79204b756e67204675,
                  128'h29c3505f571420f6402299b31a02d73a,
                  128'h54776f204f6e65204e696e652054776f};
      vecs[2] = '{128'h2b7e151628aed2a6abf7158809cf4f3c,
                  128'h3925841d02dc09fbdc118597196a0b32,
                  128'h3243f6a8885a308d313198a2e0370734};

      rst_n = 1'b0; start = 1'b0; key = '0; ciphertext = '0;
      repeat (3) @(negedge clk);
      chk("rst_busy", {127'b0, busy}, '0);
      chk("rst_done", {127'b0, done}, '0);
      chk("rst_plaintext", plaintext, '0);
      rst_n = 1'b1;

      for (int i = 0; i < 3; i++) run_op(vecs[i], i == 0);

      // Back-to-back: start held high, second start lands in the done cycle
      @(negedge clk);
      start = 1'b1; key = vecs[1].key; ciphertext = vecs[1].ct;
      sb_q.push_back(vecs[1].pt);
      lat = -1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done) begin lat = i; break; end
      end
      chk("b2b_latency1", lat, 21);
      key = vecs[0].key; ciphertext = vecs[0].ct;
      sb_q.push_back(vecs[0].pt);
      @(negedge clk);
      start = 1'b0; key = {4{$urandom}}; ciphertext = {4{$urandom}};
      chk("b2b_accept_busy", {127'b0, busy}, 128'd1);
      lat2 = -1;
      for (int i = 1; i < 41; i++) begin
         @(negedge clk);
         if (done) begin lat2 = i; break; end
      end
      chk("b2b_latency2", lat2, 21);
      last_pt = vecs[0].pt;

      // start pulses while busy are ignored
      @(negedge clk);
      start = 1'b1; key = vecs[2].key; ciphertext = vecs[2].ct;
      sb_q.push_back(vecs[2].pt);
      @(negedge clk);
      start = 1'b0;
      lat = -1; ndone = 0;
      for (int i = 0; i < 40; i++) begin
         if (i == 4 || i == 14) begin
            start = 1'b1; key = vecs[1].key; ciphertext = vecs[1].ct;
         end else begin
            start = 1'b0;
         end
         if (i == 15) chk("pt_hold", plaintext, last_pt);
         if (done) begin lat = i; ndone++; break; end
         @(negedge clk);
      end
      start = 1'b0;
      chk("busy_start_latency", lat, 21);
      repeat (25) begin
         @(negedge clk);
         if (done) ndone++;
      end
      chk("busy_start_single_done", ndone, 1);
      last_pt = vecs[2].pt;

      // Reset at E8 aborts the operation
      @(negedge clk);
      start = 1'b1; key = vecs[1].key; ciphertext = vecs[1].ct;
      @(negedge clk);
      start = 1'b0;
      repeat (7) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      chk("abort_busy", {127'b0, busy}, '0);
      chk("abort_done", {127'b0, done}, '0);
      chk("abort_plaintext", plaintext, '0);
      rst_n = 1'b1;
      ndone = 0;
      repeat (30) begin
         @(negedge clk);
         if (done) ndone++;
      end
      chk("abort_no_done", ndone, 0);
      run_op(vecs[0], 1'b0);

      repeat (3) @(negedge clk);
      chk("scoreboard_empty", sb_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
